// File: rtl/synth_pkg.sv
// synth_pkg: shared note encoding and sequencer state type for the synth tracks.
package synth_pkg;
  localparam int NOTE_W = 8;
  localparam logic [NOTE_W-1:0] REST_CODE = '0;
  localparam logic [NOTE_W-1:0] END_CODE = '1;
  typedef enum logic {IDLE, WAIT} seq_state_t;
endpackage

// File: rtl/track_sequencer_rr_arbiter.sv
// rr_arbiter_2: two-requester round-robin arbiter; a tie goes to the pointer track.
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       grant
);
  logic ptr;
  assign grant = &req ? ptr : req[1];
  // Moving at grant time matches moving at fetch completion: nothing arbitrates in between.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= 1'b0;
    else if (advance) ptr <= ~grant;
endmodule

// File: rtl/track_sequencer.sv
// track_sequencer: steps two note tracks per tempo tick through one shared note ROM.
module track_sequencer
  import synth_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        tracks_playing,
  input  logic              tempo_tick,
  output logic              mem_en,
  output logic [ADDR_W:0]   mem_addr,
  input  logic [NOTE_W-1:0] mem_rdata,
  output logic [NOTE_W-1:0] note0,
  output logic [NOTE_W-1:0] note1,
  output logic [1:0]        note_strobe,
  output logic [1:0]        overrun
);
  seq_state_t state, state_n;
  logic [1:0] pending, play_q, stop, tick_set, cap, keep;
  logic grant, g;
  logic [ADDR_W:0] addr_q;
  logic [ADDR_W-1:0] idx [2];
  logic [NOTE_W-1:0] note [2];
  rr_arbiter_2 u_arb (
    .clk(clk),
    .rst_n(rst_n),
    .req(pending),
    .advance(mem_en),
    .grant(grant)
  );
  assign stop = play_q & ~tracks_playing;
  assign tick_set = {2{tempo_tick}} & tracks_playing;
  assign cap = (state == WAIT) ? (2'b01 << g) : 2'b00;
  // A track that has stopped by the capture edge drops its in-flight data.
  assign keep = cap & tracks_playing;
  assign mem_addr = mem_en ? {grant, idx[grant]} : addr_q;
  assign note0 = note[0];
  assign note1 = note[1];
  always_comb begin
    mem_en = (state == IDLE) && |pending;
    state_n = mem_en ? WAIT : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      pending <= '0;
      play_q <= '0;
      g <= 1'b0;
      addr_q <= '0;
      note_strobe <= '0;
      overrun <= '0;
      for (int t = 0; t < 2; t++) begin
        idx[t] <= '0;
        note[t] <= REST_CODE;
      end
    end else begin
      state <= state_n;
      play_q <= tracks_playing;
      pending <= ((pending & ~cap) | tick_set) & ~stop;
      overrun <= tick_set & pending & ~cap;
      note_strobe <= keep;
      if (mem_en) begin
        g <= grant;
        addr_q <= mem_addr;
      end
      for (int t = 0; t < 2; t++)
        if (stop[t]) begin
          idx[t] <= '0;
          note[t] <= REST_CODE;
        end else if (keep[t]) begin
          idx[t] <= (mem_rdata == END_CODE) ? '0 : idx[t] + 1'b1;
          note[t] <= (mem_rdata == END_CODE) ? REST_CODE : mem_rdata;
        end
    end
endmodule

// File: tb/tb_track_sequencer.sv
// tb_track_sequencer: directed scenarios plus a randomized run against a timed server model.
module tb_track_sequencer;
  import synth_pkg::*;
  localparam int AW = 2;
  logic clk = 0, rst_n = 0, tempo_tick = 0, mem_en;
  logic [1:0] tracks_playing = 0, note_strobe, overrun;
  logic [AW:0] mem_addr;
  logic [NOTE_W-1:0] mem_rdata = 0, note0, note1;
  logic [NOTE_W-1:0] rom [2**(AW+1)];
  int checks = 0, errors = 0;

  track_sequencer #(.ADDR_W(AW)) u_dut (
    .clk(clk), .rst_n(rst_n), .tracks_playing(tracks_playing), .tempo_tick(tempo_tick),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .note0(note0), .note1(note1), .note_strobe(note_strobe), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (mem_en) mem_rdata <= rom[mem_addr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    tempo_tick = 0;
    tracks_playing = 0;
    step();
    step();
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    tracks_playing = 2'b11;
    tempo_tick = 1;
    step();
    checks++;
    if ({mem_en, mem_addr, note0, note1, note_strobe, overrun} !== 24'h0) begin
      errors++;
      $display("FAIL reset_state: en=%b addr=%h n0=%h n1=%h sb=%b ov=%b, want all zero",
               mem_en, mem_addr, note0, note1, note_strobe, overrun);
    end
    tempo_tick = 0;
    rst_n = 1;
    step();
    checks++;
    if ({mem_en, note_strobe, overrun} !== 5'h0) begin
      errors++;
      $display("FAIL reset_release: en=%b sb=%b ov=%b, want zero", mem_en, note_strobe, overrun);
    end
  endtask

  task automatic test_single();
    logic [NOTE_W-1:0] exp_n [4] = '{8'h10, 8'h12, 8'h00, 8'h10};
    logic [AW:0] exp_a [4] = '{3'd0, 3'd1, 3'd2, 3'd0};
    do_reset();
    rom[0] = 8'h10; rom[1] = 8'h12; rom[2] = END_CODE; rom[3] = 8'h55;
    tracks_playing = 2'b01;
    for (int k = 0; k < 4; k++) begin
      tempo_tick = 1;
      step();
      tempo_tick = 0;
      checks++;
      if (!(mem_en === 1'b1 && mem_addr === exp_a[k])) begin
        errors++;
        $display("FAIL single_addr[%0d]: en=%b addr=%h, want en=1 addr=%h", k, mem_en, mem_addr, exp_a[k]);
      end
      step();
      checks++;
      if (note_strobe !== 2'b00) begin
        errors++;
        $display("FAIL single_early_strobe[%0d]: sb=%b, want 00", k, note_strobe);
      end
      step();
      checks++;
      if (note0 !== exp_n[k] || note_strobe !== 2'b01) begin
        errors++;
        $display("FAIL single_note[%0d]: note0=%h sb=%b, want note0=%h sb=01", k, note0, note_strobe, exp_n[k]);
      end
      repeat (5) step();
    end
  endtask

  task automatic test_contention();
    do_reset();
    rom[0] = 8'h20; rom[1] = 8'h22; rom[4] = 8'h40; rom[5] = 8'h41;
    tracks_playing = 2'b11;
    tempo_tick = 1;
    step();
    tempo_tick = 0;
    checks++;
    if (!(mem_en === 1'b1 && mem_addr === 3'b000)) begin
      errors++;
      $display("FAIL contend_first: en=%b addr=%h, want en=1 addr=0", mem_en, mem_addr);
    end
    step();
    checks++;
    if (!(mem_en === 1'b0 && mem_addr === 3'b000)) begin
      errors++;
      $display("FAIL contend_hold: en=%b addr=%h, want en=0 addr=0", mem_en, mem_addr);
    end
    tempo_tick = 1;
    step();
    tempo_tick = 0;
    checks++;
    if (note0 !== 8'h20 || note_strobe !== 2'b01 || overrun !== 2'b10 || mem_en !== 1'b1 || mem_addr !== 3'b100) begin
      errors++;
      $display("FAIL contend_t0_done: note0=%h sb=%b ov=%b en=%b addr=%h, want 20 01 10 1 4",
               note0, note_strobe, overrun, mem_en, mem_addr);
    end
    step();
    step();
    checks++;
    if (note1 !== 8'h40 || note_strobe !== 2'b10 || mem_en !== 1'b1 || mem_addr !== 3'b001) begin
      errors++;
      $display("FAIL contend_t1_done: note1=%h sb=%b en=%b addr=%h, want 40 10 1 1",
               note1, note_strobe, mem_en, mem_addr);
    end
    step();
    step();
    checks++;
    if (note0 !== 8'h22 || note_strobe !== 2'b01 || mem_en !== 1'b0) begin
      errors++;
      $display("FAIL contend_t0_again: note0=%h sb=%b en=%b, want 22 01 0", note0, note_strobe, mem_en);
    end
  endtask

  task automatic test_overrun();
    int fetches = 0, ovr = 0, strobes = 0;
    do_reset();
    rom[0] = 8'h30;
    tracks_playing = 2'b01;
    tempo_tick = 1;
    step();
    fetches += int'(mem_en);
    step();
    tempo_tick = 0;
    ovr += int'(overrun[0]);
    checks++;
    if (overrun !== 2'b01) begin
      errors++;
      $display("FAIL overrun_pulse: ov=%b, want 01", overrun);
    end
    repeat (8) begin
      step();
      fetches += int'(mem_en);
      ovr += int'(overrun[0]);
      strobes += int'(note_strobe[0]);
    end
    checks++;
    if (fetches != 1 || ovr != 1 || strobes != 1 || note0 !== 8'h30) begin
      errors++;
      $display("FAIL overrun_counts: fetches=%0d ov=%0d strobes=%0d note0=%h, want 1 1 1 30",
               fetches, ovr, strobes, note0);
    end
  endtask

  task automatic test_stop();
    do_reset();
    rom[4] = 8'h50; rom[5] = 8'h51;
    tracks_playing = 2'b10;
    tempo_tick = 1;
    step();
    tempo_tick = 0;
    step();
    step();
    checks++;
    if (note1 !== 8'h50) begin
      errors++;
      $display("FAIL stop_first_note: note1=%h, want 50", note1);
    end
    repeat (3) step();
    tempo_tick = 1;
    step();
    tempo_tick = 0;
    checks++;
    if (mem_addr !== 3'b101) begin
      errors++;
      $display("FAIL stop_second_addr: addr=%h, want 5", mem_addr);
    end
    step();
    tracks_playing = 2'b00;
    step();
    checks++;
    if (note_strobe !== 2'b00 || note1 !== 8'h00 || mem_en !== 1'b0) begin
      errors++;
      $display("FAIL stop_discard: sb=%b note1=%h en=%b, want 00 00 0", note_strobe, note1, mem_en);
    end
    tracks_playing = 2'b10;
    step();
    tempo_tick = 1;
    step();
    tempo_tick = 0;
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== 3'b100) begin
      errors++;
      $display("FAIL stop_restart_addr: en=%b addr=%h, want 1 4", mem_en, mem_addr);
    end
  endtask

  task automatic test_wrap();
    logic [AW:0] ea;
    do_reset();
    rom[0] = 8'h01; rom[1] = 8'h02; rom[2] = 8'h03; rom[3] = 8'h04;
    tracks_playing = 2'b01;
    for (int k = 0; k < 5; k++) begin
      ea = (AW + 1)'(k % 4);
      tempo_tick = 1;
      step();
      tempo_tick = 0;
      checks++;
      if (mem_en !== 1'b1 || mem_addr !== ea) begin
        errors++;
        $display("FAIL wrap_addr[%0d]: en=%b addr=%h, want 1 %h", k, mem_en, mem_addr, ea);
      end
      step();
      step();
      checks++;
      if (note0 !== rom[ea]) begin
        errors++;
        $display("FAIL wrap_note[%0d]: note0=%h, want %h", k, note0, rom[ea]);
      end
      repeat (2) step();
    end
  endtask

  task automatic test_async_reset();
    int bad = 0;
    do_reset();
    rom[0] = 8'h60; rom[1] = 8'h61;
    tracks_playing = 2'b01;
    tempo_tick = 1;
    step();
    tempo_tick = 0;
    repeat (4) step();
    tempo_tick = 1;
    step();
    tempo_tick = 0;
    step();
    #3 rst_n = 0;
    #1;
    checks++;
    if ({mem_en, mem_addr, note0, note1, note_strobe, overrun} !== 24'h0) begin
      errors++;
      $display("FAIL async_reset: en=%b addr=%h n0=%h n1=%h sb=%b ov=%b, want all zero",
               mem_en, mem_addr, note0, note1, note_strobe, overrun);
    end
    step();
    rst_n = 1;
    repeat (6) begin
      step();
      bad += int'(note_strobe != 2'b00) + int'(mem_en);
    end
    checks++;
    if (bad != 0 || note0 !== 8'h00) begin
      errors++;
      $display("FAIL async_after: activity=%0d note0=%h, want 0 00", bad, note0);
    end
  endtask

  // Shared ROM modelled as a server: a fetch seen at cycle n completes at n+2.
  task automatic test_random();
    logic [AW-1:0] m_idx [2];
    logic [NOTE_W-1:0] m_note [2];
    logic [NOTE_W-1:0] v;
    logic [1:0] pend, exp_sb, exp_ov;
    logic [AW:0] exp_addr;
    logic rr, exp_en, tk, g;
    int cur, done_at;
    do_reset();
    for (int i = 0; i < 2**(AW+1); i++) begin
      v = NOTE_W'($urandom_range(1, 254));
      rom[i] = ($urandom_range(0, 5) == 0) ? END_CODE : v;
    end
    m_idx[0] = 0; m_idx[1] = 0;
    m_note[0] = REST_CODE; m_note[1] = REST_CODE;
    pend = 0; rr = 0; exp_addr = 0; cur = -1; done_at = 0;
    tracks_playing = 2'b11;
    for (int n = 0; n < 400; n++) begin
      tk = (n < 380) && ($urandom_range(0, 2) == 0);
      tempo_tick = tk;
      step();
      exp_sb = 0;
      exp_ov = 0;
      if (cur >= 0 && n == done_at) begin
        v = rom[{cur[0], m_idx[cur]}];
        m_note[cur] = (v == END_CODE) ? REST_CODE : v;
        m_idx[cur] = (v == END_CODE) ? '0 : m_idx[cur] + 1'b1;
        exp_sb[cur] = 1'b1;
        pend[cur] = 1'b0;
        rr = ~cur[0];
        cur = -1;
      end
      if (tk) begin
        exp_ov = pend;
        pend = 2'b11;
      end
      exp_en = (cur < 0) && (pend != 2'b00);
      if (exp_en) begin
        g = (pend == 2'b11) ? rr : pend[1];
        exp_addr = {g, m_idx[g]};
        cur = int'(g);
        done_at = n + 2;
      end
      checks++;
      if (mem_en !== exp_en || mem_addr !== exp_addr) begin
        errors++;
        $display("FAIL rand_fetch@%0d: en=%b addr=%h, want en=%b addr=%h", n, mem_en, mem_addr, exp_en, exp_addr);
      end
      checks++;
      if (note_strobe !== exp_sb || overrun !== exp_ov) begin
        errors++;
        $display("FAIL rand_pulses@%0d: sb=%b ov=%b, want sb=%b ov=%b", n, note_strobe, overrun, exp_sb, exp_ov);
      end
      checks++;
      if (note0 !== m_note[0] || note1 !== m_note[1]) begin
        errors++;
        $display("FAIL rand_notes@%0d: n0=%h n1=%h, want n0=%h n1=%h", n, note0, note1, m_note[0], m_note[1]);
      end
    end
    tempo_tick = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_overrun();
    test_stop();
    test_wrap();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
